// File: rtl/pc_pkg.sv
// Shared constants and types for the program counter.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEF = 4;
  localparam int unsigned PC_RESET_DEF = 0;

  typedef logic [PC_WIDTH_DEF-1:0] pc_addr_t;

endpackage

// File: rtl/pc_incr.sv
// Combinational WIDTH-bit +1 incrementer; wraps to zero, carry discarded.
module pc_incr
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] incr
);

  assign incr = value + WIDTH'(1);

endmodule

// File: rtl/pc.sv
// Program counter: synchronous clear, then increment, then hold.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned RESET_VAL = PC_RESET_DEF
) (
  input  logic             clk,
  input  logic             IPC,
  input  logic             CLR,
  output logic [WIDTH-1:0] PC_addr
);

  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);

  // Initialiser gives a defined value before the first clear in simulation.
  logic [WIDTH-1:0] pc_q = ResetVal;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;

  pc_incr #(
    .WIDTH(WIDTH)
  ) u_incr (
    .value(pc_q),
    .incr (pc_inc)
  );

  always_comb begin
    pc_d = pc_q;
    if (IPC) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      pc_q <= ResetVal;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_addr = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed sequences plus randomized mid-cycle toggling.
module tb_pc;

  logic       clk;
  logic       IPC;
  logic       CLR;
  logic [3:0] pc_a;
  logic [4:0] pc_b;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integer counters with modular arithmetic.
  int ma = 0;
  int mb = 3;

  pc u_dut (
    .clk    (clk),
    .IPC    (IPC),
    .CLR    (CLR),
    .PC_addr(pc_a)
  );

  pc #(
    .WIDTH    (5),
    .RESET_VAL(3)
  ) u_dut_alt (
    .clk    (clk),
    .IPC    (IPC),
    .CLR    (CLR),
    .PC_addr(pc_b)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_edge(input logic clr, input logic ipc);
    if (clr) begin
      ma = 0;
      mb = 3;
    end else if (ipc) begin
      ma = (ma + 1) % 16;
      mb = (mb + 1) % 32;
    end
  endfunction

  task automatic step(input string tag, input logic clr, input logic ipc);
    CLR = clr;
    IPC = ipc;
    @(posedge clk);
    model_edge(clr, ipc);
    #1;
    check({tag, "_a"}, int'(pc_a), ma);
    check({tag, "_b"}, int'(pc_b), mb);
    @(negedge clk);
  endtask

  initial begin
    logic c;
    logic i;
    CLR = 1'b0;
    IPC = 1'b0;
    #1;
    check("init_a", int'(pc_a), 0);
    check("init_b", int'(pc_b), 3);

    // Clear for two edges, then idle for ten.
    repeat (2) step("clr", 1'b1, 1'b0);
    repeat (10) step("idle", 1'b0, 1'b0);
    check("idle_zero", int'(pc_a), 0);

    // Count 1..5 from zero.
    for (int k = 1; k <= 5; k++) begin
      step("count", 1'b0, 1'b1);
      check("count_seq", int'(pc_a), k);
    end

    // Full 16-step run from zero ends in wrap to 0.
    step("clr2", 1'b1, 1'b0);
    repeat (16) step("wrap", 1'b0, 1'b1);
    check("wrap_zero", int'(pc_a), 0);

    // Hold at 7 for three edges, then resume at 8.
    repeat (7) step("to7", 1'b0, 1'b1);
    repeat (3) step("hold", 1'b0, 1'b0);
    check("hold_7", int'(pc_a), 7);
    step("resume", 1'b0, 1'b1);
    check("resume_8", int'(pc_a), 8);

    // Clear and increment together at 9: clear wins, then 1, 2.
    step("to9", 1'b0, 1'b1);
    check("at_9", int'(pc_a), 9);
    step("clr_ipc", 1'b1, 1'b1);
    check("clr_wins_a", int'(pc_a), 0);
    check("clr_wins_b", int'(pc_b), 3);
    repeat (4) step("clr_ipc", 1'b1, 1'b1);
    step("after_clr", 1'b0, 1'b1);
    check("after_clr_1", int'(pc_a), 1);
    check("after_clr_b", int'(pc_b), 4);
    step("after_clr", 1'b0, 1'b1);
    check("after_clr_2", int'(pc_a), 2);

    // Random toggling between edges; only the value present at the edge counts.
    for (int n = 0; n < 300; n++) begin
      CLR = 1'($urandom_range(0, 9) == 0);
      IPC = 1'($urandom);
      #1;
      check("mid_a", int'(pc_a), ma);
      check("mid_b", int'(pc_b), mb);
      c = 1'($urandom_range(0, 9) == 0);
      i = 1'($urandom_range(0, 3) != 0);
      step("rand", c, i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
